// File: rtl/debouncer_multi.sv
// debouncer_multi: N-channel push-button debouncer.
// Per channel: 2-FF synchroniser, saturating-window debounce counter,
// registered level output, one-cycle press/release pulses and an
// optional hold-to-repeat pulse generator. Channels share only the clock
// and reset; there is no arbitration between them.
module debouncer_multi #(
    parameter int CHANNELS     = 4,
    parameter int CNT_WIDTH    = 17,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_EN    = 1,
    parameter int RPT_WIDTH    = 26,
    parameter int REPEAT_FIRST = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] botoes,
    output logic [CHANNELS-1:0] saida,
    output logic [CHANNELS-1:0] pulso_press,
    output logic [CHANNELS-1:0] pulso_solta,
    output logic [CHANNELS-1:0] pulso_repete
);

    // Raw inputs are XORed with this so that 1 always means "pressed".
    localparam logic INV_BIT = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Counter value on the edge where the stability window completes.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Repeat counter terminal values: a pulse fires when rc reaches these.
    localparam logic [RPT_WIDTH-1:0] RPT_FIRST_LAST = RPT_WIDTH'(REPEAT_FIRST - 1);
    localparam logic [RPT_WIDTH-1:0] RPT_RATE_LAST  = RPT_WIDTH'(REPEAT_RATE - 1);
    localparam logic [RPT_WIDTH-1:0] RPT_ZERO       = {RPT_WIDTH{1'b0}};
    localparam logic [RPT_WIDTH-1:0] RPT_ONE        = RPT_WIDTH'(1);

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_FIRST = 2'd1,
        RPT_RATE  = 2'd2
    } rpt_state_t;

    genvar i;
    for (i = 0; i < CHANNELS; i++) begin : g_ch
        logic                 s0_r;
        logic                 s1_r;
        logic [CNT_WIDTH-1:0] cnt_r;
        logic                 saida_r;
        logic                 press_r;
        logic                 solta_r;
        logic                 idle_s;
        logic                 window_done_s;
        logic                 rise_s;
        logic                 fall_s;

        // Decode the debounce state: idle when the synchronised input
        // already matches the output, toggle when the window fills up.
        always_comb begin
            idle_s        = (saida_r == s1_r);
            window_done_s = (!idle_s) && (cnt_r == CNT_LAST);
            rise_s        = window_done_s && !saida_r;
            fall_s        = window_done_s && saida_r;
        end

        // Two-flop synchroniser with polarity normalisation on entry.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                s0_r <= 1'b0;
                s1_r <= 1'b0;
            end else begin
                s0_r <= botoes[i] ^ INV_BIT;
                s1_r <= s0_r;
            end
        end

        // Stability window counter and debounced level; any return of the
        // input to the current level restarts the window from zero.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_r   <= {CNT_WIDTH{1'b0}};
                saida_r <= 1'b0;
            end else if (idle_s) begin
                cnt_r   <= {CNT_WIDTH{1'b0}};
                saida_r <= saida_r;
            end else begin
                cnt_r   <= cnt_r + CNT_ONE;
                saida_r <= saida_r ^ window_done_s;
            end
        end

        // Edge pulses, registered on the same edge the level changes so
        // they are high for exactly the cycle following that edge.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                press_r <= 1'b0;
                solta_r <= 1'b0;
            end else begin
                press_r <= rise_s;
                solta_r <= fall_s;
            end
        end

        assign saida[i]       = saida_r;
        assign pulso_press[i] = press_r;
        assign pulso_solta[i] = solta_r;

        if (REPEAT_EN != 0) begin : g_rpt
            rpt_state_t           state_r;
            rpt_state_t           state_s;
            logic [RPT_WIDTH-1:0] rc_r;
            logic [RPT_WIDTH-1:0] rc_s;
            logic                 rpt_pulse_s;
            logic                 rpt_r;

            // Repeat FSM state and counter registers.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state_r <= RPT_IDLE;
                    rc_r    <= RPT_ZERO;
                    rpt_r   <= 1'b0;
                end else begin
                    state_r <= state_s;
                    rc_r    <= rc_s;
                    rpt_r   <= rpt_pulse_s;
                end
            end

            // Repeat FSM next state; a release overrides everything so no
            // repeat pulse can coincide with or follow the release pulse.
            always_comb begin
                state_s     = state_r;
                rc_s        = rc_r;
                rpt_pulse_s = 1'b0;
                if (fall_s) begin
                    state_s = RPT_IDLE;
                    rc_s    = RPT_ZERO;
                end else begin
                    case (state_r)
                        RPT_IDLE: begin
                            rc_s = RPT_ZERO;
                            if (rise_s) begin
                                state_s = RPT_FIRST;
                            end else begin
                                state_s = RPT_IDLE;
                            end
                        end
                        RPT_FIRST: begin
                            if (rc_r == RPT_FIRST_LAST) begin
                                rpt_pulse_s = 1'b1;
                                rc_s        = RPT_ZERO;
                                state_s     = RPT_RATE;
                            end else begin
                                rc_s = rc_r + RPT_ONE;
                            end
                        end
                        RPT_RATE: begin
                            if (rc_r == RPT_RATE_LAST) begin
                                rpt_pulse_s = 1'b1;
                                rc_s        = RPT_ZERO;
                            end else begin
                                rc_s = rc_r + RPT_ONE;
                            end
                        end
                        default: begin
                            state_s = RPT_IDLE;
                            rc_s    = RPT_ZERO;
                        end
                    endcase
                end
            end

            assign pulso_repete[i] = rpt_r;
        end else begin : g_no_rpt
            assign pulso_repete[i] = 1'b0;
        end
    end

endmodule
